// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Bundle of handshake and data signals between fetch/register-read, the ALU
// issue stage and execute.
//   Upstream side : in_valid, in_ready, in_inst, in_pc, in_rs1, in_rs2, flush
//   Execute side  : out_valid, out_ready, x, y, funct7, funct3, opcode,
//                   imm, pc, rd (and illegal when ALU_ISSUE_ILLEGAL_TRAP_EN)
// Modports:
//   master : environment driving instructions and consuming ALU inputs
//   slave  : the issue stage itself
// Optional macro: ALU_ISSUE_ILLEGAL_TRAP_EN adds the 'illegal' signal.
// ---------------------------------------------------------------------------
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] x;
   logic [31:0] y;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [6:0]  opcode;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [4:0]  rd;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   modport master (
      output in_valid, in_inst, in_pc, in_rs1, in_rs2, flush, out_ready,
      input  in_ready, out_valid, x, y, funct7, funct3, opcode, imm, pc, rd
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      , input illegal
`endif
   );

   modport slave (
      input  in_valid, in_inst, in_pc, in_rs1, in_rs2, flush, out_ready,
      output in_ready, out_valid, x, y, funct7, funct3, opcode, imm, pc, rd
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      , output illegal
`endif
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// RV32I decode/issue stage: turns an instruction plus its register-file data
// into ALU operands (x, y) and controls (funct7, funct3, opcode), and forwards
// pc, the decoded immediate and rd. Valid/ready handshake with an output
// register (R0) and a skid register (R1) so execute back-pressure never loses
// or duplicates an instruction.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_issue_if.slave (upstream handshake, flush, execute handshake
//           and all decoded outputs)
// Optional macro: ALU_ISSUE_ILLEGAL_TRAP_EN -- illegal instructions issue as
//   a NOP with 'illegal' set; when undefined they are accepted and dropped.
// ---------------------------------------------------------------------------
module alu_issue_stage (
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [6:0]  opcode;
      logic [4:0]  rd;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      logic        ill;
`endif
   } t_issue;

   logic [31:0] w_inst;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic        w_legal;
   t_issue      w_dec;
   logic        w_acc, w_keep, w_drain;

   t_issue      r_r0, r_r1;
   logic        r_v0, r_v1;

   assign w_inst  = bus.in_inst;
   assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
   assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
   assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                     w_inst[11:8], 1'b0};
   assign w_imm_u = {w_inst[31:12], 12'b0};
   assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                     w_inst[30:21], 1'b0};

   always_comb begin
      w_legal      = (w_inst[1:0] == 2'b11);
      w_dec        = '0;
      w_dec.pc     = bus.in_pc;
      w_dec.funct3 = w_inst[14:12];
      w_dec.opcode = w_inst[6:0];
      w_dec.rd     = w_inst[11:7];
      case (w_inst[6:2])
         OPC_OP: begin
            w_dec.x      = bus.in_rs1;
            w_dec.y      = bus.in_rs2;
            w_dec.funct7 = w_inst[31:25];
         end
         OPC_BRANCH: begin
            w_dec.x   = bus.in_rs1;
            w_dec.y   = bus.in_rs2;
            w_dec.imm = w_imm_b;
            w_dec.rd  = 5'd0;
         end
         OPC_OP_IMM: begin
            w_dec.x   = bus.in_rs1;
            w_dec.y   = w_imm_i;
            w_dec.imm = w_imm_i;
            // Only shifts carry a real funct7; elsewhere imm[10] must not
            // turn ADDI/ANDI into SUB/SRA.
            if (w_inst[14:12] == 3'b001 || w_inst[14:12] == 3'b101)
               w_dec.funct7 = w_inst[31:25];
         end
         OPC_LOAD: begin
            w_dec.x   = bus.in_rs1;
            w_dec.y   = w_imm_i;
            w_dec.imm = w_imm_i;
         end
         OPC_STORE: begin
            w_dec.x   = bus.in_rs1;
            w_dec.y   = w_imm_s;
            w_dec.imm = w_imm_s;
            w_dec.rd  = 5'd0;
         end
         OPC_JALR: begin
            w_dec.x   = bus.in_pc;
            w_dec.y   = 32'd4;
            w_dec.imm = w_imm_i;
         end
         OPC_JAL: begin
            w_dec.x   = bus.in_pc;
            w_dec.y   = 32'd4;
            w_dec.imm = w_imm_j;
         end
         OPC_AUIPC: begin
            w_dec.x   = bus.in_pc;
            w_dec.y   = w_imm_u;
            w_dec.imm = w_imm_u;
         end
         OPC_LUI: begin
            w_dec.y   = w_imm_u;
            w_dec.imm = w_imm_u;
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            w_dec.imm = w_imm_i;
         end
         default: w_legal = 1'b0;
      endcase
      // Illegal encodings reach the ALU as a NOP.
      if (!w_legal) begin
         w_dec.x      = '0;
         w_dec.y      = '0;
         w_dec.funct7 = '0;
      end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      w_dec.ill = !w_legal;
`endif
   end

   assign bus.in_ready = !r_v1;
   assign w_acc        = bus.in_valid && !r_v1;
   assign w_drain      = r_v0 && bus.out_ready;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   assign w_keep       = w_acc;
`else
   // Illegal instructions complete the handshake but are never stored.
   assign w_keep       = w_acc && w_legal;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v0        <= 1'b0;
         r_v1        <= 1'b0;
         r_r0        <= '0;
         r_r0.opcode <= 7'b0010011;
      end else if (bus.flush) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
      end else if (w_drain) begin
         if (r_v1) begin
            // in_ready is low while R1 is full, so nothing new arrives here.
            r_r0 <= r_r1;
            r_v1 <= 1'b0;
         end else if (w_keep) begin
            r_r0 <= w_dec;
         end else begin
            r_v0 <= 1'b0;
         end
      end else if (w_keep) begin
         if (!r_v0) begin
            r_r0 <= w_dec;
            r_v0 <= 1'b1;
         end else begin
            r_r1 <= w_dec;
            r_v1 <= 1'b1;
         end
      end
   end

   assign bus.out_valid = r_v0;
   assign bus.x         = r_r0.x;
   assign bus.y         = r_r0.y;
   assign bus.imm       = r_r0.imm;
   assign bus.pc        = r_r0.pc;
   assign bus.funct7    = r_r0.funct7;
   assign bus.funct3    = r_r0.funct3;
   assign bus.opcode    = r_r0.opcode;
   assign bus.rd        = r_r0.rd;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   assign bus.illegal   = r_r0.ill;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage with hand-computed expectations.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN for the illegal-instruction case.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   alu_issue_if bus ();

   alu_issue_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single accepting edge, then withdraw it.
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_chk         = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'h0;
      bus.in_pc     = 32'h0;
      bus.in_rs1    = 32'h0;
      bus.in_rs2    = 32'h0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
      chk("rst_opcode",    {25'b0, bus.opcode},    32'h13);
      chk("rst_x",         bus.x,                  32'd0);
      chk("rst_imm",       bus.imm,                32'd0);
      chk("rst_rd",        {27'b0, bus.rd},        32'd0);
      rst_n = 1'b1;
      tick();

      // ADDI x1, x2, -1
      issue(32'hFFF10093, 32'h0, 32'd5, 32'd0);
      chk("addi_valid",  {31'b0, bus.out_valid}, 32'd1);
      chk("addi_x",      bus.x,                  32'd5);
      chk("addi_y",      bus.y,                  32'hFFFFFFFF);
      chk("addi_funct7", {25'b0, bus.funct7},    32'd0);
      chk("addi_funct3", {29'b0, bus.funct3},    32'd0);
      chk("addi_rd",     {27'b0, bus.rd},        32'd1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      chk("addi_illegal", {31'b0, bus.illegal},  32'd0);
`endif
      tick();
      chk("addi_drained", {31'b0, bus.out_valid}, 32'd0);

      // SRAI x1, x2, 3: funct7 kept, shamt in y[4:0]
      issue(32'h40315093, 32'h0, 32'd0, 32'd0);
      chk("srai_funct7", {25'b0, bus.funct7},    32'h20);
      chk("srai_funct3", {29'b0, bus.funct3},    32'd5);
      chk("srai_shamt",  {27'b0, bus.y[4:0]},    32'd3);
      tick();

      // ADDI with imm 0x400: funct7 sanitised
      issue(32'h40010093, 32'h0, 32'd0, 32'd0);
      chk("addi400_funct7", {25'b0, bus.funct7}, 32'd0);
      chk("addi400_y",      bus.y,               32'h400);
      tick();

      // LUI x1, 0x12345
      issue(32'h123450B7, 32'h0, 32'hDEAD, 32'd0);
      chk("lui_x", bus.x, 32'd0);
      chk("lui_y", bus.y, 32'h12345000);
      tick();

      // JAL x1, +16 at pc 0x100
      issue(32'h010000EF, 32'h100, 32'd0, 32'd0);
      chk("jal_x",   bus.x,   32'h100);
      chk("jal_y",   bus.y,   32'd4);
      chk("jal_imm", bus.imm, 32'd16);
      chk("jal_pc",  bus.pc,  32'h100);
      tick();

      // BEQ x1, x2, +8
      issue(32'h00208463, 32'h40, 32'd7, 32'd7);
      chk("beq_x",   bus.x,            32'd7);
      chk("beq_y",   bus.y,            32'd7);
      chk("beq_imm", bus.imm,          32'd8);
      chk("beq_rd",  {27'b0, bus.rd},  32'd0);
      tick();

      // Back-pressure: ADDI x1,x0,1 / 2 / 3 streamed with out_ready low
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 32'h00100093;
      tick();
      chk("bp_ready_after1", {31'b0, bus.in_ready}, 32'd1);
      bus.in_inst = 32'h00200093;
      tick();
      chk("bp_ready_full", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_head1",      bus.y,                 32'd1);
      bus.in_inst = 32'h00300093;
      tick();
      chk("bp_hold_ready", {31'b0, bus.in_ready},  32'd0);
      chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_hold_y",     bus.y,                  32'd1);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_second",       bus.y,                 32'd2);
      chk("bp_ready_return", {31'b0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_third",       bus.y,                  32'd3);
      chk("bp_third_valid", {31'b0, bus.out_valid}, 32'd1);
      tick();
      chk("bp_empty", {31'b0, bus.out_valid}, 32'd0);

      // Flush with both entries full and an instruction presented
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 32'h00100093;
      tick();
      bus.in_inst = 32'h00200093;
      tick();
      chk("fl_full", {31'b0, bus.in_ready}, 32'd0);
      bus.flush   = 1'b1;
      bus.in_inst = 32'h00900093;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("fl_in_ready",  {31'b0, bus.in_ready},  32'd1);
      bus.out_ready = 1'b1;
      tick();
      chk("fl_dropped", {31'b0, bus.out_valid}, 32'd0);

      // Reset mid-operation discards a held entry
      bus.out_ready = 1'b0;
      issue(32'h00500093, 32'h0, 32'd0, 32'd0);
      chk("mr_held", {31'b0, bus.out_valid}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mr_valid",  {31'b0, bus.out_valid}, 32'd0);
      chk("mr_opcode", {25'b0, bus.opcode},    32'h13);
      bus.out_ready = 1'b1;
      tick();

      // Illegal instruction 0x00000000
      issue(32'h00000000, 32'h0, 32'd3, 32'd4);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      chk("ill_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("ill_flag",  {31'b0, bus.illegal},   32'd1);
      chk("ill_x",     bus.x,                  32'd0);
      chk("ill_y",     bus.y,                  32'd0);
`else
      chk("ill_dropped", {31'b0, bus.out_valid}, 32'd0);
      chk("ill_ready",   {31'b0, bus.in_ready},  32'd1);
      tick();
      chk("ill_still_dropped", {31'b0, bus.out_valid}, 32'd0);
`endif
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
